// File: rtl/modulo_empacotador_duzias.sv
// Dozen packer: counts capped bottles into a box, requests ejection of the
// full box, raises an alarm on a missing box or an eject timeout, and keeps
// a two-digit BCD count of completed boxes.
module modulo_empacotador_duzias #(
  parameter int GARRAFAS_POR_CAIXA = 12,
  parameter int TIMEOUT_CICLOS     = 8
) (
  input  logic       clk,
  input  logic       clr,
  input  logic       enable,
  input  logic       garrafa_vedada,
  input  logic       caixa_pronta,
  input  logic       caixa_ack,
  output logic       caixa_ejetar,
  output logic       parada,
  output logic       al_caixa,
  output logic       erro_garrafa,
  output logic [3:0] cont_garrafas,
  output logic [3:0] cont_caixas_d,
  output logic [3:0] cont_caixas_u,
  output logic [1:0] estado
);

  typedef enum logic [1:0] {
    ESPERA_CAIXA = 2'b00,
    ENCHENDO     = 2'b01,
    EJETANDO     = 2'b10,
    ALARME       = 2'b11
  } estado_t;

  localparam logic [3:0] LP_GARRAFAS = 4'(GARRAFAS_POR_CAIXA);
  localparam logic [3:0] LP_TIMEOUT  = 4'(TIMEOUT_CICLOS);

  estado_t    r_estado;
  logic [3:0] r_cont_garrafas;
  logic [3:0] r_timer;
  logic [3:0] r_bcd_d;
  logic [3:0] r_bcd_u;
  logic       r_ejetar;
  logic       r_alarme;
  logic       r_erro;
  logic       r_parada;

  logic [3:0] w_cont_inc;
  logic [3:0] w_timer_inc;

  // Two-digit BCD increment with wrap from 99 to 00.
  function automatic logic [7:0] f_bcd_inc(input logic [3:0] d, input logic [3:0] u);
    logic [7:0] res;
    if (u == 4'd9) begin
      if (d == 4'd9) res = 8'h00;
      else           res = {d + 4'd1, 4'd0};
    end else begin
      res = {d, u + 4'd1};
    end
    return res;
  endfunction

  assign w_cont_inc  = r_cont_garrafas + 4'd1;
  assign w_timer_inc = r_timer + 4'd1;

  // Packing FSM with all outputs registered; parada drops only while filling with the line running.
  always_ff @(posedge clk) begin
    if (!clr) begin
      r_estado        <= ESPERA_CAIXA;
      r_cont_garrafas <= 4'd0;
      r_timer         <= 4'd0;
      r_bcd_d         <= 4'd0;
      r_bcd_u         <= 4'd0;
      r_ejetar        <= 1'b0;
      r_alarme        <= 1'b0;
      r_erro          <= 1'b0;
      r_parada        <= 1'b1;
    end else begin
      r_erro   <= garrafa_vedada && !((r_estado == ENCHENDO) && enable);
      r_parada <= 1'b1;
      if (enable) begin
        case (r_estado)
          ESPERA_CAIXA: begin
            if (caixa_pronta) begin
              r_estado <= ENCHENDO;
              r_parada <= 1'b0;
            end
          end
          ENCHENDO: begin
            if (garrafa_vedada) r_cont_garrafas <= w_cont_inc;
            if (!caixa_pronta) begin
              // Box vanished under the filler: a bottle in this cycle still counts.
              r_estado <= ALARME;
              r_alarme <= 1'b1;
            end else if (garrafa_vedada && (w_cont_inc == LP_GARRAFAS)) begin
              r_estado <= EJETANDO;
              r_timer  <= 4'd0;
              r_ejetar <= 1'b1;
            end else begin
              r_parada <= 1'b0;
            end
          end
          EJETANDO: begin
            if (caixa_ack) begin
              // Ack wins over a simultaneous timeout.
              {r_bcd_d, r_bcd_u} <= f_bcd_inc(r_bcd_d, r_bcd_u);
              r_cont_garrafas    <= 4'd0;
              r_estado           <= ESPERA_CAIXA;
              r_ejetar           <= 1'b0;
            end else if (w_timer_inc == LP_TIMEOUT) begin
              r_estado <= ALARME;
              r_ejetar <= 1'b0;
              r_alarme <= 1'b1;
            end else begin
              r_timer <= w_timer_inc;
            end
          end
          default: begin
            // ALARME holds while the line keeps running; ack is ignored here.
          end
        endcase
      end else if (r_estado == ALARME) begin
        // Operator acknowledges the alarm by stopping the line; partial box is dropped.
        r_estado        <= ESPERA_CAIXA;
        r_cont_garrafas <= 4'd0;
        r_alarme        <= 1'b0;
      end
    end
  end

  assign caixa_ejetar  = r_ejetar;
  assign parada        = r_parada;
  assign al_caixa      = r_alarme;
  assign erro_garrafa  = r_erro;
  assign cont_garrafas = r_cont_garrafas;
  assign cont_caixas_d = r_bcd_d;
  assign cont_caixas_u = r_bcd_u;
  assign estado        = r_estado;

endmodule
